// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1-style UART receiver. Takes the oversample strobe from the baud
//   generator, recovers frames from the asynchronous rx line and presents each
//   received word through a one-entry valid/ready holding register. A
//   per-word framing-error flag and a sticky overrun flag go with the word.
//
// Parameters
//   Oversample  rxTick strobes per bit period (power of 2, >= 4)
//   DataBits    data bits per frame, LSB first, no parity
//   SyncStages  flip-flops in the rxIn synchronizer (>= 2)
//
// Ports
//   clk        in   system clock
//   nReset     in   asynchronous active-low reset
//   syncReset  in   synchronous reset, same effect as nReset
//   rxTick     in   oversample strobe, one clk wide
//   rxIn       in   asynchronous serial line, idles high
//   data       out  received word, held while valid
//   valid      out  data/frameErr hold a word not yet taken
//   ready      in   consumer takes the word when valid && ready
//   frameErr   out  stop bit of the held word was sampled 0
//   overrun    out  a completed frame was dropped (holding register full)
//   busy       out  receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int Oversample = 16,
   parameter int DataBits   = 8,
   parameter int SyncStages = 2
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic                syncReset,
   input  logic                rxTick,
   input  logic                rxIn,
   output logic [DataBits-1:0] data,
   output logic                valid,
   input  logic                ready,
   output logic                frameErr,
   output logic                overrun,
   output logic                busy
);

   localparam int TW = $clog2(Oversample);
   localparam int BW = $clog2(DataBits + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(Oversample - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(Oversample / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DataBits - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [SyncStages-1:0] sync_q;
   state_t                state_q,  state_d;
   logic [TW-1:0]         tick_q,   tick_d;
   logic [BW-1:0]         bit_q,    bit_d;
   logic [DataBits-1:0]   shift_q,  shift_d;
   logic [DataBits-1:0]   data_q,   data_d;
   logic                  valid_q,  valid_d;
   logic                  ferr_q,   ferr_d;
   logic                  ovr_q,    ovr_d;
   logic                  busy_q;

   logic                  rxS;
   logic                  complete;

   // Synchronized line: the FSM never looks at rxIn directly.
   assign rxS = sync_q[SyncStages-1];

   // ---------------------------------------------------------------------------
   // Receive FSM: moves only on rxTick cycles
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      complete = 1'b0;

      if (rxTick) begin
         unique case (state_q)
            IDLE: begin
               if (!rxS) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end

            START: begin
               // Re-check the line half a bit after the falling edge so that a
               // short glitch does not start a frame.
               if (tick_q == TICK_HALF) begin
                  tick_d = '0;
                  if (rxS) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     bit_d   = '0;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            DATA: begin
               // Counter wraps naturally; each wrap point is mid-bit because
               // the count was re-zeroed at the middle of the start bit.
               tick_d = tick_q + 1'b1;
               if (tick_q == TICK_LAST) begin
                  shift_d = {rxS, shift_q[DataBits-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = STOP;
                     tick_d  = '0;
                  end
               end
            end

            STOP: begin
               // Finish at mid stop bit so a back-to-back start edge is seen.
               if (tick_q == TICK_LAST) begin
                  state_d  = IDLE;
                  tick_d   = '0;
                  complete = 1'b1;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Holding register and handshake
   // ---------------------------------------------------------------------------
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (complete) begin
         // A take in the completion cycle frees the slot for the new word.
         if (!valid_q || ready) begin
            data_d  = shift_q;
            ferr_d  = !rxS;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sync_q  <= '1;
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (syncReset) begin
         sync_q  <= '1;
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SyncStages-2:0], rxIn};
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign data     = data_q;
   assign valid    = valid_q;
   assign frameErr = ferr_q;
   assign overrun  = ovr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int OS  = 16;
   localparam int DB  = 8;
   localparam int SS  = 2;
   // Start edge to valid: completion at mid stop bit, plus synchronizer,
   // plus one clk for the registered outputs.
   localparam int LAT = OS * (DB + 2) - OS / 2 + SS + 1;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          syncReset = 1'b0;
   logic          rxTick = 1'b0;
   logic          rxIn = 1'b1;
   logic [DB-1:0] data;
   logic          valid;
   logic          ready = 1'b0;
   logic          frameErr;
   logic          overrun;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Reference model of the holding register
   logic [7:0] m_data  = '0;
   logic       m_valid = 1'b0;
   logic       m_ferr  = 1'b0;
   logic       m_ovr   = 1'b0;

   int tdiv = 1;
   int tcnt = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rise_cyc = -1;
   logic valid_prev = 1'b0;

   uart_rx #(.Oversample(OS), .DataBits(DB), .SyncStages(SS)) dut (
      .clk      (clk),
      .nReset   (nReset),
      .syncReset(syncReset),
      .rxTick   (rxTick),
      .rxIn     (rxIn),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .frameErr (frameErr),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Oversample strobe: one clk high every tdiv clks
   always @(negedge clk) begin
      rxTick = (tcnt == 0);
      tcnt = (tcnt + 1 >= tdiv) ? 0 : tcnt + 1;
   end

   always @(negedge clk) begin
      if (valid && !valid_prev) rise_cyc = cyc;
      valid_prev = valid;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives a complete frame plus two idle bit periods.
   task automatic send_frame(input logic [7:0] b, input logic stopb);
      int bc;
      bc = OS * tdiv;
      @(negedge clk);
      rxIn = 1'b0;
      start_cyc = cyc;
      wait_clks(bc);
      for (int i = 0; i < DB; i++) begin
         rxIn = b[i];
         wait_clks(bc);
      end
      rxIn = stopb;
      wait_clks(bc);
      rxIn = 1'b1;
      wait_clks(2 * bc);
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stopb);
      if (!m_valid) begin
         m_data  = b;
         m_ferr  = !stopb;
         m_valid = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
   endtask

   task automatic model_take();
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      model_take();
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      wait_clks(3);
      checks++;
      if ({data, valid, frameErr, overrun, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
                  data, valid, frameErr, overrun, busy);
      end
      nReset = 1'b1;
      wait_clks(4);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got v=%b busy=%b want 0 0", valid, busy);
      end
      model_reset();
   endtask

   task automatic test_basic();
      tdiv = 1;
      rise_cyc = -1;
      send_frame(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1);
      checks++;
      if (rise_cyc - start_cyc != LAT) begin
         errors++;
         $display("FAIL t1_latency got %0d want %0d", rise_cyc - start_cyc, LAT);
      end
      checks++;
      if (valid !== m_valid || data !== m_data || frameErr !== m_ferr || overrun !== m_ovr) begin
         errors++;
         $display("FAIL t1_word got v=%b d=%h fe=%b ov=%b want v=%b d=%h fe=%b ov=%b",
                  valid, data, frameErr, overrun, m_valid, m_data, m_ferr, m_ovr);
      end
      pulse_ready();
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL t1_take got v=%b want 0", valid);
      end
   endtask

   task automatic test_glitch();
      logic saw_busy;
      saw_busy = 1'b0;
      @(negedge clk);
      rxIn = 1'b0;
      wait_clks(4 * tdiv);
      rxIn = 1'b1;
      for (int i = 0; i < 40 * tdiv; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      checks++;
      if (saw_busy !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t2_busy_pulse got saw=%b busy=%b want 1 0", saw_busy, busy);
      end
      checks++;
      if (valid !== 1'b0 || frameErr !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL t2_flags got v=%b fe=%b ov=%b want 0 0 0", valid, frameErr, overrun);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0);
      checks++;
      if (valid !== 1'b1 || data !== 8'h3C || frameErr !== 1'b1) begin
         errors++;
         $display("FAIL t3_bad_stop got v=%b d=%h fe=%b want 1 3c 1", valid, data, frameErr);
      end
      pulse_ready();
      send_frame(8'h0F, 1'b1);
      model_frame(8'h0F, 1'b1);
      checks++;
      if (valid !== 1'b1 || data !== 8'h0F || frameErr !== 1'b0) begin
         errors++;
         $display("FAIL t3_good_after got v=%b d=%h fe=%b want 1 0f 0", valid, data, frameErr);
      end
      pulse_ready();
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b1);
      model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      model_frame(8'h22, 1'b1);
      checks++;
      if (valid !== m_valid || data !== m_data || overrun !== m_ovr || frameErr !== m_ferr) begin
         errors++;
         $display("FAIL t4_overrun got v=%b d=%h ov=%b fe=%b want v=%b d=%h ov=%b fe=%b",
                  valid, data, overrun, frameErr, m_valid, m_data, m_ovr, m_ferr);
      end
      pulse_ready();
      checks++;
      if (valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL t4_take_clears got v=%b ov=%b want 0 0", valid, overrun);
      end
   endtask

   task automatic test_async_reset_mid();
      int bc;
      bc = OS * tdiv;
      send_frame(8'h77, 1'b1);
      model_frame(8'h77, 1'b1);
      @(negedge clk);
      rxIn = 1'b0;
      wait_clks(bc);
      for (int i = 0; i < 3; i++) begin
         rxIn = i[0];
         wait_clks(bc);
      end
      rxIn = 1'b1;
      wait_clks(bc / 2);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL t5_busy_before got %b want 1", busy);
      end
      nReset = 1'b0;
      @(negedge clk);
      checks++;
      if ({data, valid, frameErr, overrun, busy} !== '0) begin
         errors++;
         $display("FAIL t5_reset_clear got d=%h v=%b fe=%b ov=%b busy=%b want all 0",
                  data, valid, frameErr, overrun, busy);
      end
      nReset = 1'b1;
      model_reset();
      wait_clks(2 * bc);
      send_frame(8'h5A, 1'b1);
      model_frame(8'h5A, 1'b1);
      checks++;
      if (valid !== 1'b1 || data !== 8'h5A || frameErr !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL t5_after got v=%b d=%h fe=%b ov=%b want 1 5a 0 0",
                  valid, data, frameErr, overrun);
      end
   endtask

   task automatic test_sync_reset();
      @(negedge clk);
      rxIn = 1'b0;
      wait_clks(OS * tdiv * 2);
      syncReset = 1'b1;
      rxIn = 1'b1;
      @(negedge clk);
      syncReset = 1'b0;
      checks++;
      if ({data, valid, frameErr, overrun, busy} !== '0) begin
         errors++;
         $display("FAIL sync_reset got d=%h v=%b fe=%b ov=%b busy=%b want all 0",
                  data, valid, frameErr, overrun, busy);
      end
      model_reset();
      wait_clks(OS * tdiv * 2);
   endtask

   task automatic test_coincident_take();
      int k;
      logic busy_before;
      logic got_busy;
      tdiv = 4;
      wait_clks(8);
      send_frame(8'h01, 1'b1);
      model_frame(8'h01, 1'b1);
      // Completion is (DB+2)*OS - OS/2 ticks after the start detection.
      k = ((DB + 2) * OS - OS / 2) * tdiv - 1;
      got_busy = 1'b0;
      busy_before = 1'b0;
      fork
         send_frame(8'h80, 1'b1);
         begin
            for (int i = 0; i < 200 && !busy; i++) @(negedge clk);
            got_busy = busy;
            if (got_busy) begin
               wait_clks(k);
               busy_before = busy;
               ready = 1'b1;
               @(negedge clk);
               ready = 1'b0;
            end
         end
      join
      checks++;
      if (got_busy !== 1'b1) begin
         errors++;
         $display("FAIL t6_start_seen got busy=%b want 1", got_busy);
      end
      checks++;
      if (busy_before !== 1'b1) begin
         errors++;
         $display("FAIL t6_busy_at_completion got %b want 1", busy_before);
      end
      checks++;
      if (valid !== 1'b1 || data !== 8'h80 || overrun !== 1'b0 || frameErr !== 1'b0) begin
         errors++;
         $display("FAIL t6_coincident got v=%b d=%h ov=%b fe=%b want 1 80 0 0",
                  valid, data, overrun, frameErr);
      end
      m_data = 8'h80; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
      pulse_ready();
      tdiv = 1;
      wait_clks(8);
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       s;
      for (int n = 0; n < 10; n++) begin
         if ($urandom_range(0, 2) != 0 && m_valid) begin
            pulse_ready();
            checks++;
            if (valid !== 1'b0 || overrun !== 1'b0) begin
               errors++;
               $display("FAIL rnd_take[%0d] got v=%b ov=%b want 0 0", n, valid, overrun);
            end
         end
         b = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 3) != 0);
         send_frame(b, s);
         model_frame(b, s);
         checks++;
         if (valid !== m_valid || data !== m_data || frameErr !== m_ferr || overrun !== m_ovr) begin
            errors++;
            $display("FAIL rnd_frame[%0d] got v=%b d=%h fe=%b ov=%b want v=%b d=%h fe=%b ov=%b",
                     n, valid, data, frameErr, overrun, m_valid, m_data, m_ferr, m_ovr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_async_reset_mid();
      test_sync_reset();
      test_coincident_take();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
